// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LSB first, with a
// registered carry between slices and registered result/status flags.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic [CHUNK:0]   slice_sum;
  logic             last_slice;

  // Operands shift right each RUN cycle, so the active slice is always bits [CHUNK-1:0]
  // and, on the final slice, its top bit is the operand MSB used for overflow.
  assign slice_sum  = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry_q};
  assign last_slice = (idx_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    z_d     = z_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> CHUNK;
        opb_d   = opb_q >> CHUNK;
        carry_d = slice_sum[CHUNK];
        // New slice enters at the top; after N slices the word is fully assembled.
        acc_d   = WIDTH'({slice_sum[CHUNK-1:0], acc_q} >> CHUNK);
        idx_d   = idx_q + 1'b1;
        if (last_slice) begin
          z_d     = acc_d;
          cout_d  = slice_sum[CHUNK];
          zero_d  = (acc_d == '0);
          neg_d   = acc_d[WIDTH-1];
          ovf_d   = (opa_q[CHUNK-1] == opb_q[CHUNK-1])
                 && (slice_sum[CHUNK-1] != opa_q[CHUNK-1]);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign z    = z_q;
  assign cout = cout_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle adder/subtractor for the CPU datapath: the next-generation replacement for the fixed 8-bit ripple add/sub. It computes `a + b` or `a - b` over `WIDTH` bits, one `CHUNK`-bit slice per clock, LSB slice first, with a registered carry between slices. A start/busy/done handshake frames each operation, and the result is presented with registered status flags for the flags register.

## Interface

Parameters:
- `WIDTH`, 16: operand and result width in bits.
- `CHUNK`, 4: bits processed per cycle. Must divide `WIDTH`; `N = WIDTH/CHUNK` slices. `CHUNK = WIDTH` is legal and gives `N = 1`.

Ports:
- `clk`, in, 1: single clock, rising-edge.
- `rst_n`, in, 1: asynchronous reset, active-low.
- `start`, in, 1: request a new operation; honoured only in IDLE.
- `sub`, in, 1: 0 = add, 1 = subtract. Sampled with `start`.
- `a`, in, WIDTH: first operand. Sampled with `start`.
- `b`, in, WIDTH: second operand. Sampled with `start`.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse; result and flags are valid.
- `z`, out, WIDTH: result; held until the next operation completes.
- `cout`, out, 1: final carry out. For subtract, 1 means no borrow.
- `zero`, out, 1: `z == 0`.
- `neg`, out, 1: `z[WIDTH-1]`.
- `ovf`, out, 1: two's-complement signed overflow.

## Operation

- States are IDLE, RUN, and DONE.
- **IDLE, `start` = 1 at an edge:**
  - latch `a` into `opa`;
  - latch `b ^ {WIDTH{sub}}` into `opb`;
  - set `carry` to `sub`;
  - set slice index `idx` to 0;
  - go to RUN.
- **IDLE, `start` = 0:** remain in IDLE.
- **Each RUN edge:**
  - `{c, s} = opa[idx] + opb[idx] + carry`, where `[idx]` is a `CHUNK`-bit slice;
  - write `s` into working result slice `idx`;
  - set `carry` to `c`;
  - increment `idx`.
- **RUN edge with `idx = N-1`:**
  - copy the completed working result to `z`;
  - update `cout`, `zero`, `neg`, `ovf`;
  - go to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then go to IDLE unconditionally.
- `start` in RUN or DONE is ignored, not queued. Changes on `a`, `b`, or `sub` after the capture edge have no effect.
- **Arithmetic:** result is modulo 2^WIDTH. `ovf = (opa[MSB] == opb[MSB]) && (z[MSB] != opa[MSB])`, using the inverted `opb`.
- `z` and the flags change only at the completion edge. Between operations they hold their last values.

## Timing

- **Reset:** while `rst_n` = 0, asynchronously:
  - state = IDLE;
  - `busy`, `done`, `z`, `cout`, `zero`, `neg`, `ovf` = 0;
  - internal registers cleared.
  - Note that `zero` resets to 0 even though `z` = 0.
- **Reset mid-operation:** the operation is aborted and no `done` is issued. The first `start` after `rst_n` rises is accepted normally.
- **Latency:** `start` is captured at edge k. `busy` is high from edge k to edge k+N. `z`, the flags, and `done` are valid from edge k+N to edge k+N+1.
- **Throughput:** one operation per N+2 cycles. If `start` is held high continuously, captures occur at k, k+N+2, k+2(N+2), and so on.
- **`N = 1`:** RUN lasts one cycle; `done` appears one cycle after capture.
- `done` and `busy` are never high in the same cycle.

## Test plan

All scenarios use `WIDTH=16`, `CHUNK=4` (N = 4) unless noted.

1. **Add:** `a=0x1234`, `b=0x0FCD`, `sub=0`, pulse `start`. Expect `busy` high for 4 cycles, then `done` for one cycle, `z=0x2201`, `cout=0`, `zero=0`, `neg=0`, `ovf=0`.
2. **Subtract with borrow:** `a=0x0005`, `b=0x0007`, `sub=1`. Expect `z=0xFFFE`, `cout=0`, `neg=1`, `ovf=0`. Then `a=0x0007`, `b=0x0005`, `sub=1`: expect `z=0x0002`, `cout=1`.
3. **Boundary values:**
   - `0x7FFF + 0x0001`: `z=0x8000`, `ovf=1`, `neg=1`, `cout=0`.
   - `0xFFFF + 0x0001`: `z=0x0000`, `cout=1`, `zero=1`, `ovf=0`.
   - `0x8000 - 0x0001`: `z=0x7FFF`, `ovf=1`, `cout=1`.
4. **Handshake:**
   - Hold `start=1` continuously with `a` and `b` changing every cycle. Captures must be exactly 6 cycles apart. Each result must match the operands present on its capture edge.
   - `z` must stay stable from one `done` until the next.
5. **Reset mid-RUN:** drive `rst_n` low two cycles after capture. All outputs go to 0 immediately (asynchronously) and no `done` is issued. After release, `0x0001 + 0x0001` completes with `z=0x0002`.
6. **`CHUNK=16` (N = 1):** `0xABCD - 0xABCD` gives `z=0`, `zero=1`, `cout=1`, with `done` one cycle after capture. Also check random regressions against a reference model for `CHUNK` = 1, 2, 8.
